// File: rtl/heater_actuator_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : heater_actuator_ctrl_pkg
// Brief   : State encoding, default timing and helpers for the heater relay
//           actuator controller.
// Revision: 1.0 - initial release
// ============================================================================
package heater_actuator_ctrl_pkg;

    localparam int c_STATE_W = 3;

    // Encodings are visible on state_o and shared with heating_system tooling.
    localparam logic [c_STATE_W-1:0] c_HS_LOCKOUT = 3'd0;
    localparam logic [c_STATE_W-1:0] c_HS_IDLE    = 3'd1;
    localparam logic [c_STATE_W-1:0] c_HS_DEAD    = 3'd2;
    localparam logic [c_STATE_W-1:0] c_HS_ON_MIN  = 3'd3;
    localparam logic [c_STATE_W-1:0] c_HS_ON      = 3'd4;
    localparam logic [c_STATE_W-1:0] c_HS_FAULT   = 3'd5;

    typedef enum logic [c_STATE_W-1:0] {
        ST_LOCKOUT = c_HS_LOCKOUT,
        ST_IDLE    = c_HS_IDLE,
        ST_DEAD    = c_HS_DEAD,
        ST_ON_MIN  = c_HS_ON_MIN,
        ST_ON      = c_HS_ON,
        ST_FAULT   = c_HS_FAULT
    } heater_state_t;

    localparam int c_DEF_MIN_ON_CYC     = 600;
    localparam int c_DEF_MIN_OFF_CYC    = 300;
    localparam int c_DEF_DEAD_CYC       = 16;
    localparam int c_DEF_FB_TIMEOUT_CYC = 50;
    localparam int c_DEF_CNT_W          = 16;

    function automatic logic f_is_on(input heater_state_t s);
        return (s == ST_ON_MIN) || (s == ST_ON);
    endfunction

endpackage
`default_nettype wire

// File: rtl/heater_actuator_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : heater_actuator_ctrl_if
// Brief   : Request/interlock/feedback inputs and relay/status outputs of the
//           heater actuator controller.
// Revision: 1.0 - initial release
// ============================================================================
interface heater_actuator_ctrl_if;
    import heater_actuator_ctrl_pkg::*;

    logic                 heat_req;
    logic                 ac_cool;
    logic                 window;
    logic                 relay_fb;
    logic                 fault_clr;
    logic                 heater_en;
    logic                 heater_active;
    logic                 fault;
    logic [c_STATE_W-1:0] state_o;

    modport master (
        output heat_req, ac_cool, window, relay_fb, fault_clr,
        input  heater_en, heater_active, fault, state_o
    );

    modport slave (
        input  heat_req, ac_cool, window, relay_fb, fault_clr,
        output heater_en, heater_active, fault, state_o
    );

endinterface
`default_nettype wire

// File: rtl/heater_actuator_ctrl_hold_timer.sv
`default_nettype none
// ============================================================================
// Module  : heater_actuator_ctrl_hold_timer
// Brief   : Loadable down counter that saturates at zero; times lockout,
//           dead-time and minimum-on intervals.
// Revision: 1.0 - initial release
// ============================================================================
module heater_actuator_ctrl_hold_timer #(
    parameter int               CNT_W   = 16,
    parameter logic [CNT_W-1:0] RST_VAL = '0
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_load,
    input  wire logic [CNT_W-1:0] i_value,
    input  wire logic             i_dec,
    output      logic             o_zero
);

    localparam logic [CNT_W-1:0] c_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= RST_VAL;
        end else if (i_load) begin
            r_cnt <= i_value;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - c_ONE;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/heater_actuator_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : heater_actuator_ctrl
// Brief   : Heater relay driver with anti-short-cycle timing, pre-start dead
//           time, window/AC interlock and latched relay-feedback fault.
// Revision: 1.0 - initial release
// ============================================================================
module heater_actuator_ctrl
    import heater_actuator_ctrl_pkg::*;
#(
    parameter int MIN_ON_CYC     = c_DEF_MIN_ON_CYC,
    parameter int MIN_OFF_CYC    = c_DEF_MIN_OFF_CYC,
    parameter int DEAD_CYC       = c_DEF_DEAD_CYC,
    parameter int FB_TIMEOUT_CYC = c_DEF_FB_TIMEOUT_CYC,
    parameter int CNT_W          = c_DEF_CNT_W
) (
    input wire logic              clk,
    input wire logic              rst,
    heater_actuator_ctrl_if.slave hac
);

    localparam logic [CNT_W-1:0] c_MIN_ON_LD  = CNT_W'(MIN_ON_CYC - 1);
    localparam logic [CNT_W-1:0] c_MIN_OFF_LD = CNT_W'(MIN_OFF_CYC - 1);
    localparam logic [CNT_W-1:0] c_DEAD_LD    = CNT_W'(DEAD_CYC - 1);
    localparam logic [CNT_W-1:0] c_FB_LAST    = CNT_W'(FB_TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] c_ONE        = {{(CNT_W-1){1'b0}}, 1'b1};

    heater_state_t    r_state;
    heater_state_t    w_state_nxt;
    logic             r_heater_en;
    logic             r_heater_active;
    logic             r_fault;
    logic [CNT_W-1:0] r_fb_cnt;

    logic             w_ilk;
    logic             w_valid;
    logic             w_fb_timeout;
    logic             w_load;
    logic [CNT_W-1:0] w_load_val;
    logic             w_dec;
    logic             w_zero;

    assign w_ilk   = hac.window | hac.ac_cool;
    assign w_valid = hac.heat_req & ~w_ilk;

    // Fires on the edge at which the open-contact count would reach the limit.
    assign w_fb_timeout = r_heater_en & ~hac.relay_fb & (r_fb_cnt == c_FB_LAST);

    heater_actuator_ctrl_hold_timer #(
        .CNT_W   (CNT_W),
        .RST_VAL (c_MIN_OFF_LD)
    ) u_hold_timer (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load),
        .i_value (w_load_val),
        .i_dec   (w_dec),
        .o_zero  (w_zero)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_load_val  = c_MIN_OFF_LD;
        w_dec       = 1'b0;
        case (r_state)
            ST_LOCKOUT: begin
                w_dec = 1'b1;
                if (w_zero) w_state_nxt = ST_IDLE;
            end
            ST_IDLE: begin
                if (w_valid) begin
                    w_state_nxt = ST_DEAD;
                    w_load      = 1'b1;
                    w_load_val  = c_DEAD_LD;
                end
            end
            ST_DEAD: begin
                w_dec = 1'b1;
                if (!w_valid) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_zero) begin
                    w_state_nxt = ST_ON_MIN;
                    w_load      = 1'b1;
                    w_load_val  = c_MIN_ON_LD;
                end
            end
            ST_ON_MIN: begin
                w_dec = 1'b1;
                if (w_fb_timeout) begin
                    w_state_nxt = ST_FAULT;
                end else if (w_ilk) begin
                    w_state_nxt = ST_LOCKOUT;
                    w_load      = 1'b1;
                end else if (w_zero) begin
                    // A request dropped during min-on is honoured once it expires.
                    if (hac.heat_req) begin
                        w_state_nxt = ST_ON;
                    end else begin
                        w_state_nxt = ST_LOCKOUT;
                        w_load      = 1'b1;
                    end
                end
            end
            ST_ON: begin
                if (w_fb_timeout) begin
                    w_state_nxt = ST_FAULT;
                end else if (!w_valid) begin
                    w_state_nxt = ST_LOCKOUT;
                    w_load      = 1'b1;
                end
            end
            ST_FAULT: begin
                if (hac.fault_clr) begin
                    w_state_nxt = ST_LOCKOUT;
                    w_load      = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_LOCKOUT;
                w_load      = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= ST_LOCKOUT;
            r_heater_en     <= 1'b0;
            r_heater_active <= 1'b0;
            r_fault         <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_heater_en     <= f_is_on(w_state_nxt);
            r_heater_active <= r_heater_en & hac.relay_fb & f_is_on(w_state_nxt);
            r_fault         <= (w_state_nxt == ST_FAULT);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fb_cnt <= '0;
        end else if (!r_heater_en || hac.relay_fb) begin
            r_fb_cnt <= '0;
        end else if (r_fb_cnt != '1) begin
            r_fb_cnt <= r_fb_cnt + c_ONE;
        end
    end

    assign hac.heater_en     = r_heater_en;
    assign hac.heater_active = r_heater_active;
    assign hac.fault         = r_fault;
    assign hac.state_o       = r_state;

endmodule
`default_nettype wire

// File: tb/tb_heater_actuator_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_heater_actuator_ctrl
// Brief   : Directed scenarios plus randomized traffic against an elapsed-time
//           reference model of the heater actuator controller.
// Revision: 1.0 - initial release
// ============================================================================
module tb_heater_actuator_ctrl;

    localparam int MIN_ON  = 8;
    localparam int MIN_OFF = 6;
    localparam int DEAD    = 4;
    localparam int FB_TO   = 3;

    localparam int M_LOCK  = 0;
    localparam int M_IDLE  = 1;
    localparam int M_DEAD  = 2;
    localparam int M_ONMIN = 3;
    localparam int M_ON    = 4;
    localparam int M_FAULT = 5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    heater_actuator_ctrl_if u_if ();

    heater_actuator_ctrl #(
        .MIN_ON_CYC     (MIN_ON),
        .MIN_OFF_CYC    (MIN_OFF),
        .DEAD_CYC       (DEAD),
        .FB_TIMEOUT_CYC (FB_TO),
        .CNT_W          (16)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .hac (u_if)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: phase plus cycles elapsed inside it.
    int m_mode;
    int m_age;
    int m_fb_low;
    bit m_en;
    bit m_act;
    bit m_flt;
    bit relay_auto;
    bit relay_stuck;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_mode   = M_LOCK;
        m_age    = 0;
        m_fb_low = 0;
        m_en     = 1'b0;
        m_act    = 1'b0;
        m_flt    = 1'b0;
    endtask

    task automatic model_step();
        bit ilk, valid, tmo, on;
        int nm;
        ilk   = u_if.window | u_if.ac_cool;
        valid = u_if.heat_req & ~ilk;
        tmo   = m_en && !u_if.relay_fb && (m_fb_low + 1 >= FB_TO);
        nm    = m_mode;
        case (m_mode)
            M_LOCK:  if (m_age >= MIN_OFF - 1) nm = M_IDLE;
            M_IDLE:  if (valid) nm = M_DEAD;
            M_DEAD: begin
                if (!valid) nm = M_IDLE;
                else if (m_age >= DEAD - 1) nm = M_ONMIN;
            end
            M_ONMIN: begin
                if (tmo) nm = M_FAULT;
                else if (ilk) nm = M_LOCK;
                else if (m_age >= MIN_ON - 1) nm = u_if.heat_req ? M_ON : M_LOCK;
            end
            M_ON: begin
                if (tmo) nm = M_FAULT;
                else if (!valid) nm = M_LOCK;
            end
            default: if (u_if.fault_clr) nm = M_LOCK;
        endcase
        on       = (nm == M_ONMIN) || (nm == M_ON);
        m_act    = m_en && u_if.relay_fb && on;
        m_fb_low = (m_en && !u_if.relay_fb) ? m_fb_low + 1 : 0;
        m_en     = on;
        m_flt    = (nm == M_FAULT);
        m_age    = (nm == m_mode) ? m_age + 1 : 0;
        m_mode   = nm;
    endtask

    task automatic check_all();
        chk("state_o", u_if.state_o, m_mode);
        chk("heater_en", u_if.heater_en, m_en);
        chk("heater_active", u_if.heater_active, m_act);
        chk("fault", u_if.fault, m_flt);
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        if (relay_auto) u_if.relay_fb = m_en;
        check_all();
    endtask

    task automatic wait_mode(input int target, input string tag);
        for (int i = 0; i < 40 && m_mode != target; i++) step();
        chk(tag, u_if.state_o, target);
    endtask

    int rise;
    int cnt;
    bit en_seen;

    initial begin
        rst              = 1'b1;
        u_if.heat_req    = 1'b0;
        u_if.ac_cool     = 1'b0;
        u_if.window      = 1'b0;
        u_if.relay_fb    = 1'b0;
        u_if.fault_clr   = 1'b0;
        relay_auto       = 1'b1;
        relay_stuck      = 1'b0;
        model_reset();

        // Reset state, then request immediately on release.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all();
        #1 rst = 1'b0;
        u_if.heat_req = 1'b1;
        rise = 0;
        for (int i = 1; i <= 30; i++) begin
            step();
            if (u_if.heater_en === 1'b1) begin
                rise = i;
                break;
            end
        end
        chk("rise_edges_after_reset", rise, MIN_OFF + DEAD + 1);
        repeat (4) step();

        // Return to idle, then a short request pulse aborts the dead time.
        u_if.heat_req = 1'b0;
        wait_mode(M_IDLE, "reach_idle_1");
        u_if.heat_req = 1'b1;
        step();
        step();
        u_if.heat_req = 1'b0;
        en_seen = 1'b0;
        repeat (10) begin
            step();
            en_seen |= u_if.heater_en;
        end
        chk("pulse_no_heater_en", en_seen, 1'b0);
        chk("pulse_stays_idle", u_if.state_o, M_IDLE);

        // Request dropped one cycle into min-on.
        u_if.heat_req = 1'b1;
        for (int i = 0; i < 20 && u_if.heater_en !== 1'b1; i++) step();
        cnt = 1;
        step();
        if (u_if.heater_en === 1'b1) cnt++;
        u_if.heat_req = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (u_if.heater_en !== 1'b1) break;
            cnt++;
        end
        chk("min_on_cycles", cnt, MIN_ON);
        cnt = (u_if.state_o === 3'(M_LOCK)) ? 1 : 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (u_if.state_o !== 3'(M_LOCK)) break;
            cnt++;
        end
        chk("lockout_after_drop", cnt, MIN_OFF);

        // Window opens during min-on.
        u_if.heat_req = 1'b1;
        for (int i = 0; i < 20 && u_if.heater_en !== 1'b1; i++) step();
        step();
        step();
        u_if.window = 1'b1;
        step();
        chk("window_en_off", u_if.heater_en, 1'b0);
        chk("window_lockout", u_if.state_o, M_LOCK);
        u_if.window = 1'b0;
        cnt = 1;
        for (int i = 0; i < 30; i++) begin
            step();
            if (u_if.state_o !== 3'(M_LOCK)) break;
            cnt++;
        end
        chk("window_lockout_len", cnt, MIN_OFF);
        chk("window_then_idle", u_if.state_o, M_IDLE);

        // Relay never closes: feedback fault, then acknowledge.
        relay_auto    = 1'b0;
        u_if.relay_fb = 1'b0;
        for (int i = 0; i < 20 && u_if.heater_en !== 1'b1; i++) step();
        repeat (3) step();
        chk("fb_fault_set", u_if.fault, 1'b1);
        chk("fb_fault_en_off", u_if.heater_en, 1'b0);
        chk("fb_fault_state", u_if.state_o, M_FAULT);
        repeat (4) step();
        u_if.fault_clr = 1'b1;
        step();
        u_if.fault_clr = 1'b0;
        chk("fault_cleared", u_if.fault, 1'b0);
        chk("fault_clr_lockout", u_if.state_o, M_LOCK);
        relay_auto = 1'b1;

        // Asynchronous reset in the middle of ON.
        wait_mode(M_ON, "reach_on");
        #3 rst = 1'b1;
        #1;
        chk("async_rst_en", u_if.heater_en, 1'b0);
        chk("async_rst_state", u_if.state_o, M_LOCK);
        chk("async_rst_active", u_if.heater_active, 1'b0);
        model_reset();
        u_if.relay_fb = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        cnt = 0;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (u_if.state_o !== 3'(M_LOCK)) begin
                cnt = i;
                break;
            end
        end
        chk("rst_lockout_edges", cnt, MIN_OFF);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(7) == 0) u_if.heat_req = ~u_if.heat_req;
            u_if.window    = ($urandom_range(29) == 0);
            u_if.ac_cool   = ($urandom_range(39) == 0);
            u_if.fault_clr = ($urandom_range(9) == 0);
            if ($urandom_range(99) == 0) relay_stuck = ~relay_stuck;
            if (relay_stuck) u_if.relay_fb = 1'b0;
            else if ($urandom_range(19) == 0) u_if.relay_fb = ~u_if.relay_fb;
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
